// File: rtl/gpio_evt_pkg.sv
// Shared constants and helpers for the GPIO event capture block.
package gpio_evt_pkg;

  localparam logic MODE_CHANGE = 1'b0;
  localparam logic MODE_EXT    = 1'b1;

  localparam int DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = DROP_CNT_W'(255);

  // Occupancy counters need one extra bit to represent "full".
  function automatic int clog2p1(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/gpio_evt_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module gpio_evt_fifo
  import gpio_evt_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [DATA_W-1:0]           wdata,
  input  logic                        pop,
  output logic [DATA_W-1:0]           rdata,
  output logic                        full,
  output logic                        empty,
  output logic [clog2p1(DEPTH)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = clog2p1(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage is not reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/gpio_event_capture.sv
// Watches a GPIO bus and queues timestamped events, triggered either by
// masked bit changes or by edges of an asynchronous external strobe.
module gpio_event_capture
  import gpio_evt_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 8,
  parameter int TS_W        = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_i,
  input  logic                        mode_i,
  input  logic [WIDTH-1:0]            mask_i,
  input  logic [WIDTH-1:0]            gpio_i,
  input  logic                        ext_clk_i,
  output logic                        evt_valid_o,
  input  logic                        evt_ready_i,
  output logic [WIDTH-1:0]            evt_gpio_o,
  output logic                        evt_ext_o,
  output logic [TS_W-1:0]             evt_ts_o,
  output logic [clog2p1(DEPTH)-1:0]   level_o,
  output logic                        ovf_o,
  output logic [DROP_CNT_W-1:0]       drop_cnt_o,
  input  logic                        ovf_clr_i
);

  localparam int DATA_W = TS_W + 1 + WIDTH;

  logic [WIDTH-1:0]       gpio_q, last_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ext_lvl, ext_prev;
  logic                   en_q, mode_q;
  logic [TS_W-1:0]        ts_q;

  logic              rebase, hit_chg, hit_ext, evt, evt_ext, pop, drop;
  logic              full, empty;
  logic [DATA_W-1:0] wdata, rdata;

  // ext_clk_i: synchroniser chain, then a level flop and the edge-detect flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_q   <= '0;
      last_q   <= '0;
      sync_q   <= '0;
      ext_lvl  <= 1'b0;
      ext_prev <= 1'b0;
      en_q     <= 1'b0;
      mode_q   <= MODE_CHANGE;
      ts_q     <= '0;
    end else begin
      gpio_q   <= gpio_i;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], ext_clk_i};
      ext_lvl  <= sync_q[SYNC_STAGES-1];
      ext_prev <= ext_lvl;
      en_q     <= en_i;
      mode_q   <= mode_i;
      ts_q     <= ts_q + 1'b1;
      if (en_i) last_q <= gpio_q;
    end
  end

  // A freshly enabled or re-moded cycle only captures the baseline.
  assign rebase  = ~en_q | (mode_i != mode_q);
  assign hit_chg = |((gpio_q ^ last_q) & mask_i);
  assign hit_ext = ext_lvl ^ ext_prev;
  assign evt     = en_i & ~rebase & ((mode_i == MODE_CHANGE) ? hit_chg : hit_ext);
  assign evt_ext = (mode_i == MODE_EXT) & ext_lvl;
  assign wdata   = {ts_q, evt_ext, gpio_q};

  assign pop  = evt_valid_o & evt_ready_i;
  assign drop = evt & full & ~pop;

  gpio_evt_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (evt),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level_o)
  );

  assign evt_valid_o = ~empty;
  assign {evt_ts_o, evt_ext_o, evt_gpio_o} = empty ? '0 : rdata;

  // A clear that coincides with a drop leaves that one drop recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_o      <= 1'b0;
      drop_cnt_o <= '0;
    end else if (ovf_clr_i) begin
      ovf_o      <= drop;
      drop_cnt_o <= {{(DROP_CNT_W-1){1'b0}}, drop};
    end else if (drop) begin
      ovf_o <= 1'b1;
      if (drop_cnt_o != DROP_CNT_MAX) drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end

endmodule

// File: doc/gpio_event_capture.md
Name: gpio_event_capture

Overview:
- Synthesisable, parametrised successor to the GPIO monitor: watches a WIDTH-bit GPIO bus and emits timestamped events into an internal FIFO.
- Two capture modes:
  - change mode: any masked bit change generates an event.
  - external-strobe mode: each synchronised edge of ext_clk_i generates an event.
- Sits beside the GPIO port of the microcontroller. Its event stream feeds a CPU-readable event register or a trace buffer through a valid/ready handshake.

Parameters:
- WIDTH, 32, GPIO bus width (1..64).
- DEPTH, 8, event FIFO depth; power of two, >=2.
- TS_W, 16, timestamp counter width.
- SYNC_STAGES, 2, synchroniser flops on ext_clk_i (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- en_i  in  1  capture enable
- mode_i  in  1  0 = change mode, 1 = external-strobe mode
- mask_i  in  WIDTH  per-bit change-detect enable (change mode only)
- gpio_i  in  WIDTH  GPIO bus, synchronous to clk
- ext_clk_i  in  1  external strobe, asynchronous
- evt_valid_o  out  1  FIFO head valid
- evt_ready_i  in  1  consumer accepts head
- evt_gpio_o  out  WIDTH  captured GPIO value
- evt_ext_o  out  1  ext_clk level after the edge (0 in change mode)
- evt_ts_o  out  TS_W  timestamp of the event
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy
- ovf_o  out  1  sticky overflow flag
- drop_cnt_o  out  8  dropped-event count, saturating at 255
- ovf_clr_i  in  1  clears ovf_o and drop_cnt_o

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - FIFO empty.
  - evt_valid_o=0, level_o=0, ovf_o=0, drop_cnt_o=0.
  - Timestamp counter=0, baseline register=0, synchroniser=0.
  - evt_gpio_o/evt_ext_o/evt_ts_o driven 0 while empty.
- Input registering: gpio_i is registered into gpio_q every cycle. ext_clk_i passes through SYNC_STAGES flops, then one edge-detect flop.
- Timestamp: free-running, +1 per cycle, wraps 2^TS_W-1 -> 0. It is not gated by en_i.
- Baseline: on the first cycle en_i=1 after reset, after en_i=0, or after any mode_i change:
  - last_q <= gpio_q and the edge flop <= synced level.
  - No event is generated in that cycle.
- Change mode, per enabled cycle:
  - hit = |((gpio_q ^ last_q) & mask_i).
  - last_q <= gpio_q every cycle, so changes on masked-off bits are absorbed silently.
  - Each hit produces one event: gpio=gpio_q, ext=0, ts=counter value in the detect cycle.
- External-strobe mode:
  - A rising or falling edge of the synchronised ext_clk produces one event: gpio=gpio_q, ext=new level, ts=current counter.
  - mask_i is ignored.
  - Edges closer than SYNC_STAGES+1 cycles are not guaranteed distinct.
- Latency:
  - gpio_i change before edge k -> gpio_q at edge k -> FIFO write at edge k+1 -> evt_valid_o high after edge k+1.
  - ext_clk_i adds SYNC_STAGES+1 cycles.
- FIFO behaviour:
  - First-word-fall-through.
  - evt_valid_o = !empty.
  - Pop when evt_valid_o && evt_ready_i.
  - Push accepted when !full, or when full with a simultaneous pop.
  - level_o updates on the same edge as the push/pop.
  - Push and pop in the same cycle leave level_o unchanged.
- Overflow:
  - An event arriving at a full FIFO with no pop is dropped.
  - On a drop, ovf_o<=1 and drop_cnt_o increments, saturating at 255.
  - ovf_clr_i clears both. If ovf_clr_i coincides with a drop, ovf_o=1 and drop_cnt_o=1.
- en_i=0: no events are generated. The FIFO still drains and the timestamp still runs.
- rst asserted mid-operation: all pending events are discarded on that edge.

Decomposition:
- Package gpio_evt_pkg holds:
  - MODE_CHANGE=1'b0, MODE_EXT=1'b1
  - DROP_CNT_W=8, DROP_CNT_MAX=255
  - a level-width function clog2p1(DEPTH)
- One sub-module, gpio_evt_fifo:
  - synchronous FWFT FIFO, parameters DATA_W and DEPTH
  - ports: push, pop, full, empty, level
- The top level concatenates {ts, ext, gpio} into DATA_W = TS_W+1+WIDTH.

Test Plan:
- Change mode, mask=32'hFFFF_FFFF, gpio 0 -> 32'h0000_00A5 at cycle 10, ready=1 -> one event, gpio=32'hA5, ext=0, ts=11, evt_valid_o high 2 cycles after the change.
- Change mode, mask=32'h0000_00FF, toggle bit 8 then bit 0 -> bit 8 gives no event; bit 0 gives one event with bit 8 value retained in gpio.
- External mode, SYNC_STAGES=2, gpio=32'h1234, ext_clk pulse 6 cycles wide -> two events: ext=1 then ext=0, both gpio=32'h1234, ts separated by 6.
- DEPTH=8, ready=0, 10 change events -> level_o=8, ovf_o=1, drop_cnt_o=2. Then ovf_clr_i coinciding with an 11th event -> ovf_o=1, drop_cnt_o=1.
- FIFO full, event coinciding with pop -> event accepted, level_o stays 8, no drop.
- rst pulse with level_o=5 -> next cycle evt_valid_o=0, level_o=0, ts=0. The first enabled cycle after reset re-baselines with no event even though gpio≠0.
